// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-channel alarm engine with snooze, dismiss and daily repeat.
// Define ALARM_BEEP_EN to pulse the sounder 1 s on / 1 s off instead of a steady ring.
module alarm_bank #(
  parameter int N_ALARMS   = 4,
  parameter int TIME_W     = 64,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int DAY_SEC    = 86400,
  localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [TIME_W-1:0] now,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              wr_arm,
  input  logic              wr_daily,
  input  logic              snooze_btn,
  input  logic              dismiss_btn,
  output logic              ring,
  output logic              ringing,
  output logic              snoozed,
  output logic [IDX_W-1:0]  active_idx,
  output logic [N_ALARMS-1:0] pending
);

  localparam int RC_W = $clog2(RING_SEC + 1);
  localparam int SC_W = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam logic [RC_W-1:0]   RING_LAST = RC_W'(RING_SEC - 1);
  localparam logic [SC_W-1:0]   SNZ_INIT  = SC_W'(SNOOZE_SEC);
  localparam logic [SC_W-1:0]   SNZ_ONE   = SC_W'(1);
  localparam logic [TIME_W-1:0] DAY_INC   = TIME_W'(DAY_SEC);

  typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZE} state_t;

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   time_q [N_ALARMS];
  logic [TIME_W-1:0]   time_d [N_ALARMS];
  logic [N_ALARMS-1:0] arm_q, arm_d, daily_q, daily_d, pending_q, pending_d;
  logic [IDX_W-1:0]    active_q, active_d, first_idx;
  logic [RC_W-1:0]     ring_cnt_q, ring_cnt_d;
  logic [SC_W-1:0]     snz_cnt_q, snz_cnt_d;
  logic                service, wr_ok, wr_active;

  assign wr_ok     = wr_en && ({1'b0, wr_idx} < (IDX_W + 1)'(N_ALARMS));
  assign wr_active = wr_ok && (state_q != S_IDLE) && (wr_idx == active_q);

  always_comb begin
    first_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      active_q   <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      arm_q      <= '0;
      daily_q    <= '0;
      pending_q  <= '0;
      for (int i = 0; i < N_ALARMS; i++) time_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      arm_q      <= arm_d;
      daily_q    <= daily_d;
      pending_q  <= pending_d;
      for (int i = 0; i < N_ALARMS; i++) time_q[i] <= time_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    service    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ring_cnt_d = '0;
        if (|pending_q) begin
          active_d = first_idx;
          state_d  = S_RINGING;
        end
      end
      S_RINGING: begin
        if (sec_tick) ring_cnt_d = ring_cnt_q + 1'b1;
        if (dismiss_btn) begin
          service = 1'b1;
          state_d = S_IDLE;
        end else if (snooze_btn) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = SNZ_INIT;
        end else if (sec_tick && ring_cnt_q == RING_LAST) begin
          service = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SNOOZE: begin
        if (sec_tick) snz_cnt_d = snz_cnt_q - 1'b1;
        if (dismiss_btn) begin
          service = 1'b1;
          state_d = S_IDLE;
        end else if (sec_tick && snz_cnt_q == SNZ_ONE) begin
          state_d    = S_RINGING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reconfiguring the serviced channel abandons it; the new settings must not be serviced.
    if (wr_active) begin
      state_d = S_IDLE;
      service = 1'b0;
    end
  end

  always_comb begin
    arm_d     = arm_q;
    daily_d   = daily_q;
    pending_d = pending_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      time_d[i] = time_q[i];
      if (sec_tick && arm_q[i] && time_q[i] == now) pending_d[i] = 1'b1;
      if (service && IDX_W'(i) == active_q) begin
        pending_d[i] = 1'b0;
        if (daily_q[i]) time_d[i] = time_q[i] + DAY_INC;
        else            arm_d[i]  = 1'b0;
      end
      if (wr_ok && IDX_W'(i) == wr_idx) begin
        time_d[i]    = wr_time;
        arm_d[i]     = wr_arm;
        daily_d[i]   = wr_daily;
        pending_d[i] = 1'b0;
      end
    end
  end

`ifdef ALARM_BEEP_EN
  logic beep_q, beep_d;

  assign beep_d = (state_q != S_RINGING) ? 1'b1 : (sec_tick ? ~beep_q : beep_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beep_q <= 1'b1;
    else     beep_q <= beep_d;
  end
`endif

  always_comb begin
    ringing = (state_q == S_RINGING);
    snoozed = (state_q == S_SNOOZE);
`ifdef ALARM_BEEP_EN
    ring    = ringing & beep_q;
`else
    ring    = ringing;
`endif
  end

  assign active_idx = active_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - scoreboard bench for alarm_bank, default build.
module tb_alarm_bank;
  localparam int N  = 4;
  localparam int TW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          sec_tick, wr_en, wr_arm, wr_daily, snooze_btn, dismiss_btn;
  logic [TW-1:0] now, wr_time;
  logic [1:0]    wr_idx;
  logic          ring, ringing, snoozed;
  logic [1:0]    active_idx;
  logic [N-1:0]  pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          tk;
    logic [63:0] t;
    bit          wr;
    logic [1:0]  idx;
    logic [63:0] wt;
    bit          arm;
    bit          dly;
    bit          snz;
    bit          dis;
    logic [8:0]  exp;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  alarm_bank dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .now(now),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_time(wr_time), .wr_arm(wr_arm), .wr_daily(wr_daily),
    .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
    .ring(ring), .ringing(ringing), .snoozed(snoozed), .active_idx(active_idx), .pending(pending)
  );

  // Expected {ring, ringing, snoozed, active_idx, pending}; steady ring equals ringing.
  function automatic logic [8:0] ex(bit rg, bit sn, int idx, logic [3:0] p);
    return {rg, rg, sn, 2'(idx), p};
  endfunction

  function automatic void push(string n, bit tk, longint t, bit wr, int idx, longint wt,
                               bit arm, bit dly, bit snz, bit dis, logic [8:0] e);
    step_t s;
    s.name = n; s.tk = tk; s.t = 64'(t); s.wr = wr; s.idx = 2'(idx); s.wt = 64'(wt);
    s.arm = arm; s.dly = dly; s.snz = snz; s.dis = dis; s.exp = e;
    sb.push_back(s);
  endfunction

  function automatic void p_idle(string n, logic [8:0] e);
    push(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction

  function automatic void p_tick(string n, longint t, logic [8:0] e);
    push(n, 1, t, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction

  function automatic void p_wr(string n, int idx, longint wt, bit arm, bit dly, logic [8:0] e);
    push(n, 0, 0, 1, idx, wt, arm, dly, 0, 0, e);
  endfunction

  function automatic void p_btn(string n, bit snz, bit dis, logic [8:0] e);
    push(n, 0, 0, 0, 0, 0, 0, 0, snz, dis, e);
  endfunction

  task automatic apply(input step_t s);
    if (s.tk) now = s.t;
    sec_tick = s.tk; wr_en = s.wr; wr_idx = s.idx; wr_time = s.wt;
    wr_arm = s.arm; wr_daily = s.dly; snooze_btn = s.snz; dismiss_btn = s.dis;
    @(posedge clk);
    #1;
    sec_tick = 1'b0; wr_en = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
  endtask

  task automatic test_reset;
    step_t s;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ring, ringing, snoozed, active_idx, pending} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {ring, ringing, snoozed, active_idx, pending}, 9'b0);
    end
    rst = 1'b0;
    p_tick("reset_ch0_unarmed", 0, ex(0, 0, 0, 4'b0000));
    p_idle("reset_no_ring", ex(0, 0, 0, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_single;
    step_t s;
    p_wr("single_write", 1, 1000, 1, 0, ex(0, 0, 0, 4'b0000));
    p_tick("single_pending", 1000, ex(0, 0, 0, 4'b0010));
    p_idle("single_ringing", ex(1, 0, 1, 4'b0010));
    p_btn("single_dismiss", 0, 1, ex(0, 0, 1, 4'b0000));
    p_tick("single_disarmed", 1000, ex(0, 0, 1, 4'b0000));
    p_idle("single_no_ring", ex(0, 0, 1, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_snooze_daily;
    step_t s;
    p_wr("daily_write", 0, 500, 1, 1, ex(0, 0, 1, 4'b0000));
    p_tick("daily_pending", 500, ex(0, 0, 1, 4'b0001));
    p_idle("daily_ringing", ex(1, 0, 0, 4'b0001));
    p_btn("daily_snooze", 1, 0, ex(0, 1, 0, 4'b0001));
    for (int k = 1; k <= 300; k++) begin
      if (k < 300) p_tick($sformatf("snz_tick%0d", k), 500 + k, ex(0, 1, 0, 4'b0001));
      else         p_tick("snz_expire", 500 + k, ex(1, 0, 0, 4'b0001));
    end
    p_btn("daily_dismiss", 0, 1, ex(0, 0, 0, 4'b0000));
    p_tick("daily_next_day", 86900, ex(0, 0, 0, 4'b0001));
    p_idle("daily_rings_again", ex(1, 0, 0, 4'b0001));
    p_btn("daily_dismiss2", 0, 1, ex(0, 0, 0, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_two_channels;
    step_t s;
    p_wr("two_write2", 2, 2000, 1, 0, ex(0, 0, 0, 4'b0000));
    p_wr("two_write3", 3, 2000, 1, 0, ex(0, 0, 0, 4'b0000));
    p_tick("two_pending", 2000, ex(0, 0, 0, 4'b1100));
    p_idle("two_ring_ch2", ex(1, 0, 2, 4'b1100));
    p_btn("two_dismiss_ch2", 0, 1, ex(0, 0, 2, 4'b1000));
    p_idle("two_ring_ch3", ex(1, 0, 3, 4'b1000));
    p_btn("two_dismiss_ch3", 0, 1, ex(0, 0, 3, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_timeout_and_buttons;
    step_t s;
    p_wr("auto_write", 1, 3000, 1, 0, ex(0, 0, 3, 4'b0000));
    p_tick("auto_pending", 3000, ex(0, 0, 3, 4'b0010));
    p_idle("auto_ringing", ex(1, 0, 1, 4'b0010));
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) p_tick($sformatf("auto_tick%0d", k), 3000 + k, ex(1, 0, 1, 4'b0010));
      else        p_tick("auto_dismissed", 3000 + k, ex(0, 0, 1, 4'b0000));
    end
    p_wr("both_write", 2, 4000, 1, 0, ex(0, 0, 1, 4'b0000));
    p_tick("both_pending", 4000, ex(0, 0, 1, 4'b0100));
    p_idle("both_ringing", ex(1, 0, 2, 4'b0100));
    p_btn("both_dismiss_wins", 1, 1, ex(0, 0, 2, 4'b0000));
    p_wr("tosnz_write", 3, 5000, 1, 0, ex(0, 0, 2, 4'b0000));
    p_tick("tosnz_pending", 5000, ex(0, 0, 2, 4'b1000));
    p_idle("tosnz_ringing", ex(1, 0, 3, 4'b1000));
    for (int k = 1; k < 60; k++) p_tick($sformatf("tosnz_tick%0d", k), 5000 + k, ex(1, 0, 3, 4'b1000));
    push("tosnz_snooze_wins", 1, 5060, 0, 0, 0, 0, 0, 1, 0, ex(0, 1, 3, 4'b1000));
    p_btn("tosnz_dismiss", 0, 1, ex(0, 0, 3, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_write_conflict;
    step_t s;
    p_wr("wc_write", 1, 6000, 1, 0, ex(0, 0, 3, 4'b0000));
    push("wc_write_beats_match", 1, 6000, 1, 1, 6000, 1, 0, 0, 0, ex(0, 0, 3, 4'b0000));
    p_idle("wc_no_ring", ex(0, 0, 3, 4'b0000));
    p_tick("wc_pending", 6000, ex(0, 0, 3, 4'b0010));
    p_idle("wc_ringing", ex(1, 0, 1, 4'b0010));
    p_wr("wc_write_active", 1, 7000, 1, 0, ex(0, 0, 1, 4'b0000));
    p_idle("wc_stays_idle", ex(0, 0, 1, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_ring;
    step_t s;
    p_tick("rmr_pending", 173300, ex(0, 0, 1, 4'b0001));
    p_idle("rmr_ringing", ex(1, 0, 0, 4'b0001));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ring, ringing, snoozed, active_idx, pending} !== 9'b0) begin
      failures++;
      $display("FAIL rmr_reset_outputs got=%b exp=%b", {ring, ringing, snoozed, active_idx, pending}, 9'b0);
    end
    rst = 1'b0;
    p_tick("rmr_ch0_disarmed_old", 173300, ex(0, 0, 0, 4'b0000));
    p_tick("rmr_ch0_disarmed_zero", 0, ex(0, 0, 0, 4'b0000));
    p_idle("rmr_idle", ex(0, 0, 0, 4'b0000));
    while (sb.size() > 0) begin
      s = sb.pop_front(); apply(s); checks++;
      if ({ring, ringing, snoozed, active_idx, pending} !== s.exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.name, {ring, ringing, snoozed, active_idx, pending}, s.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; now = '0; wr_en = 1'b0; wr_idx = '0; wr_time = '0;
    wr_arm = 1'b0; wr_daily = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
    test_reset();
    test_single();
    test_snooze_daily();
    test_two_channels();
    test_timeout_and_buttons();
    test_write_conflict();
    test_reset_mid_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
